// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I integer execution unit: issue latch, compute, result queue
module alu_exec_unit #(
  parameter int ROB_TAG_W = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [2:0]           issue_op_L1,
  input  logic                 issue_op_L2,
  input  logic [31:0]          issue_opr1,
  input  logic [31:0]          issue_opr2,
  input  logic [ROB_TAG_W-1:0] issue_rob_id,
  output logic                 alu_full,
  output logic                 result_valid,
  output logic [31:0]          result_value,
  output logic [ROB_TAG_W-1:0] result_rob_id,
  input  logic                 result_grant
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           s1_op_q, s1_op_d;
  logic                 s1_l2_q, s1_l2_d;
  logic [31:0]          s1_a_q, s1_a_d;
  logic [31:0]          s1_b_q, s1_b_d;
  logic [ROB_TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic [31:0]          val_mem_q [OUT_DEPTH];
  logic [ROB_TAG_W-1:0] tag_mem_q [OUT_DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic [CW-1:0]        occ;
  logic                 accept, push, pop;
  logic [31:0]          alu_res;
  logic signed [31:0]   sra_res;

  // Occupancy counts the op sitting in stage 1 so a push can never overflow the queue.
  assign occ          = count_q + {{PW{1'b0}}, s1_valid_q};
  assign alu_full     = (occ >= CW'(OUT_DEPTH));
  assign accept       = issue_valid && !alu_full && !flush;
  assign push         = s1_valid_q && !flush;
  assign result_valid = (count_q != '0);
  assign pop          = result_valid && result_grant && !flush;
  assign result_value  = result_valid ? val_mem_q[head_q] : '0;
  assign result_rob_id = result_valid ? tag_mem_q[head_q] : '0;

  // Kept apart so the arithmetic shift is not evaluated in an unsigned context.
  assign sra_res = $signed(s1_a_q) >>> s1_b_q[4:0];

  always_comb begin
    alu_res = '0;
    case (s1_op_q)
      3'b000:  alu_res = s1_l2_q ? (s1_a_q - s1_b_q) : (s1_a_q + s1_b_q);
      3'b001:  alu_res = s1_a_q << s1_b_q[4:0];
      3'b010:  alu_res = {31'b0, ($signed(s1_a_q) < $signed(s1_b_q))};
      3'b011:  alu_res = {31'b0, (s1_a_q < s1_b_q)};
      3'b100:  alu_res = s1_a_q ^ s1_b_q;
      3'b101:  alu_res = s1_l2_q ? unsigned'(sra_res) : (s1_a_q >> s1_b_q[4:0]);
      3'b110:  alu_res = s1_a_q | s1_b_q;
      default: alu_res = s1_a_q & s1_b_q;
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = s1_op_q;
    s1_l2_d    = s1_l2_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (accept) begin
      s1_op_d  = issue_op_L1;
      s1_l2_d  = issue_op_L2;
      s1_a_d   = issue_opr1;
      s1_b_d   = issue_opr2;
      s1_tag_d = issue_rob_id;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_l2_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_l2_q    <= s1_l2_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      val_mem_q[tail_q] <= alu_res;
      tag_mem_q[tail_q] <= s1_tag_q;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit on the consuming end of the reservation station issue interface.
- Accepts at most one ready ALU operation per cycle and computes the RV32I result.
- Queues results and broadcasts them on the ALU result bus (valid/value/ROB tag) back to the reservation station, ROB and LSB.
- Provides a full signal so the reservation station stops issuing, plus a flush input for mispredict recovery.

Parameters:
ROB_TAG_W, 4, width of ROB tag, equal to ROB_WIDTH+1 of the codebase
OUT_DEPTH, 2, result queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-low reset
flush  in  1  mispredict clear; drops all in-flight work
issue_valid  in  1  RS presents an operation this cycle
issue_op_L1  in  3  funct3 selector
issue_op_L2  in  1  funct7[5] modifier (sub / sra)
issue_opr1  in  32  operand 1
issue_opr2  in  32  operand 2 (register or immediate)
issue_rob_id  in  ROB_TAG_W  destination ROB tag
alu_full  out  1  RS must not assert issue_valid next cycle
result_valid  out  1  result_value/result_rob_id valid (new_alu_result)
result_value  out  32  computed value
result_rob_id  out  ROB_TAG_W  tag being resolved (alu_dependency)
result_grant  in  1  result bus accepted head result this cycle

Behaviour:
- Reset (rst low, async):
  - Stage-1 register invalid; queue empty (head=tail=0, count=0).
  - Outputs: result_valid=0, result_value=0, result_rob_id=0, alu_full=0.
  - Reset can hit mid-operation; all in-flight work is lost.
- Stage 1 (issue latch):
  - On posedge, if issue_valid && !alu_full && !flush, latch op/operands/tag into s1 and set s1_valid=1.
  - Otherwise s1_valid is cleared.
  - Issue while alu_full=1 is a protocol violation; the op is ignored and nothing changes.
- Stage 2 (compute/push): if s1_valid && !flush, push the result into the queue tail on the same posedge.
- Operation encoding:
  - 000: add; sub when L2=1
  - 001: sll
  - 010: slt (signed)
  - 011: sltu
  - 100: xor
  - 101: srl; sra when L2=1
  - 110: or
  - 111: and
- Arithmetic rules:
  - Shift amount is opr2[4:0].
  - Add/sub wraps mod 2^32.
  - slt/sltu yield 32'h0000_0001 or 0.
  - L2 is ignored for all ops except 000 and 101.
- Output:
  - result_* are driven combinationally from the queue head.
  - result_valid = (count != 0).
  - When result_valid=0, result_value and result_rob_id hold 0.
- Pop: on posedge when result_valid && result_grant && !flush; head advances mod OUT_DEPTH.
- Latency: issue accepted at edge N -> result_valid=1 after edge N+1, provided the queue was empty. Sustains 1 op/cycle when grant is held high.
- Occupancy and alu_full:
  - occ = count + s1_valid.
  - alu_full = (occ >= OUT_DEPTH), registered-state based only, with no combinational path from issue_valid.
  - Sizing guarantees a push never meets a full queue. The bench asserts that push with count==OUT_DEPTH never occurs.
- Simultaneous push and pop:
  - count is unchanged; head and tail both advance.
  - With count==1, the old head leaves and the new result becomes the head on the next cycle.
- Flush (sampled on posedge, highest priority after reset):
  - s1_valid=0, count=0, head=tail=0.
  - Any issue, push or pop in that cycle is discarded.
  - result_valid=0 from the next cycle.
- Wrap-around: head/tail are log2(OUT_DEPTH)-bit pointers. count has one extra bit so that count==OUT_DEPTH is representable.

Test Plan:
- Reset then ALU ops:
  - Reset low 3 cycles; outputs must read all 0.
  - Issue add 5+7 tag 3 with grant=1 -> result_valid=1, value 12, tag 3 exactly 2 cycles after issue; valid drops the next cycle.
- Op sweep:
  - sub 3-5 -> 0xFFFFFFFE
  - sra 0x80000000>>4 -> 0xF8000000
  - srl same -> 0x08000000
  - slt -1<1 -> 1; sltu -1<1 -> 0
  - sll 1<<33 -> 2 (shift by 1)
- Back-pressure:
  - grant=0, issue 3 back-to-back ops (tags 1,2,3) respecting alu_full.
  - alu_full asserts after the second accepted op; a third issue while full is ignored.
  - Raise grant: results for tags 1 then 2 appear in order, one per cycle; alu_full then deasserts.
- Simultaneous push and pop: queue holds tag 1, s1 holds tag 2, grant=1 -> tag 1 output this cycle, tag 2 next cycle, count never exceeds 1.
- Flush mid-stream: 2 results queued plus s1 valid, assert flush one cycle with issue_valid=1 -> next cycle result_valid=0 and alu_full=0; the issued op is never broadcast.
- Async reset mid-operation: drop rst between clock edges while result_valid=1 -> result_valid falls immediately without a clock edge; after release, normal issue works.
